// File: rtl/video_out_pkg.sv
// Shared types, timing helpers and colour-bar table for the video output engine.
package video_out_pkg;

  typedef enum logic [1:0] {
    PIX_RAW8   = 2'd0,
    PIX_RGB565 = 2'd1,
    PIX_RGB888 = 2'd2,
    PIX_RSVD   = 2'd3
  } pix_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } tg_state_t;

  // Per-pixel timing word carried alongside the FIFO read latency.
  typedef struct packed {
    logic      de;
    logic      hs;
    logic      vs;
    logic      fs;
    logic      ufl;
    logic      tpg;
    logic [2:0] bar;
    pix_mode_t mode;
  } tmg_t;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vo_pix_unpack.sv
// Unpacks one FIFO word to 8:8:8 RGB by pixel mode; registered output, black when not enabled.
module vo_pix_unpack
  import video_out_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  pix_mode_t         mode,
  input  logic [DATA_W-1:0] data,
  input  logic              pix_en,
  input  logic              ovr_en,
  input  logic [23:0]       ovr_rgb,
  output logic [23:0]       rgb
);

  logic [23:0] d;
  logic [23:0] pix;

  always_comb begin
    d   = 24'(data);
    pix = '0;
    case (mode)
      PIX_RAW8:   pix = {d[7:0], d[7:0], d[7:0]};
      PIX_RGB565: pix = {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
      PIX_RGB888: pix = d;
      default:    pix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         rgb <= '0;
    else if (ovr_en) rgb <= ovr_rgb;
    else if (pix_en) rgb <= pix;
    else             rgb <= '0;
  end

endmodule

// File: rtl/video_out_tgen.sv
// Programmable raster generator with FIFO read control and RGB unpacking.
// Optional colour-bar test pattern enabled by defining VIDEO_OUT_TPG_EN.
//   state   | meaning
//   ST_IDLE | stopped, counters at 0, no reads
//   ST_WAIT | enabled, waiting for fifo_ready before first frame
//   ST_RUN  | counters free-run, reads during active video
module video_out_tgen
  import video_out_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int DATA_W   = 16,
  parameter int FIFO_LAT = 1
) (
`ifdef VIDEO_OUT_TPG_EN
  input  logic              tpg_sel,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              fifo_ready,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              clr_status,
  output logic              vs,
  output logic              hs,
  output logic              de,
  output logic [7:0]        rgb_r,
  output logic [7:0]        rgb_g,
  output logic [7:0]        rgb_b,
  output logic              frame_start,
  output logic              underflow
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  tg_state_t     state;
  pix_mode_t     mode_q;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          run, h_last, v_last, frame_last, latch_cfg, tpg_q;
  logic          de_i, hs_i, vs_i, fs_i, ufl_i;
  logic [2:0]    bar_i;
  tmg_t          tmg_i, ret;
  tmg_t          pipe [FIFO_LAT];
  logic [23:0]   rgb_q;

  assign run        = (state == ST_RUN);
  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_last = run && h_last && v_last;
  // Configuration is only taken at a frame boundary so a frame never mixes formats.
  assign latch_cfg  = ((state == ST_WAIT) && enable && fifo_ready) || (frame_last && enable);

  assign de_i = run && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs_i = run && (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_i = run && (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
  assign fs_i = de_i && (h_cnt == '0) && (v_cnt == '0);

  assign fifo_rd_en = de_i && !tpg_q;
  assign ufl_i      = fifo_rd_en && fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= PIX_RAW8;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      if (latch_cfg) mode_q <= pix_mode_t'(mode);
      unique case (state)
        ST_IDLE: if (enable) state <= ST_WAIT;
        ST_WAIT: begin
          if (!enable)        state <= ST_IDLE;
          else if (fifo_ready) state <= ST_RUN;
        end
        ST_RUN: begin
          if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
          if (frame_last && !enable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VIDEO_OUT_TPG_EN
  always_ff @(posedge clk) begin
    if (rst)            tpg_q <= 1'b0;
    else if (latch_cfg) tpg_q <= tpg_sel;
  end
  assign bar_i = 3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));
`else
  assign tpg_q = 1'b0;
  assign bar_i = 3'd0;
`endif

  assign tmg_i = '{de: de_i, hs: hs_i, vs: vs_i, fs: fs_i, ufl: ufl_i,
                   tpg: tpg_q, bar: bar_i, mode: mode_q};

  // Timing word waits out the FIFO read latency so it meets its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tmg_i;
      for (int i = 1; i < FIFO_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ret = pipe[FIFO_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      hs          <= !HS_POL;
      vs          <= !VS_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      de          <= ret.de;
      hs          <= ret.hs ? HS_POL : !HS_POL;
      vs          <= ret.vs ? VS_POL : !VS_POL;
      frame_start <= ret.fs;
      if (ufl_i)           underflow <= 1'b1;
      else if (clr_status) underflow <= 1'b0;
    end
  end

  vo_pix_unpack #(.DATA_W(DATA_W)) u_unpack (
    .clk     (clk),
    .rst     (rst),
    .mode    (ret.mode),
    .data    (fifo_rd_data),
    .pix_en  (ret.de && !ret.ufl && !ret.tpg),
    .ovr_en  (ret.de && ret.tpg),
    .ovr_rgb (BAR_RGB[ret.bar]),
    .rgb     (rgb_q)
  );

  assign rgb_r = rgb_q[23:16];
  assign rgb_g = rgb_q[15:8];
  assign rgb_b = rgb_q[7:0];

endmodule

// File: tb/tb_video_out_tgen.sv
// Directed bench for video_out_tgen: two instances (active-high syncs/latency 1, active-low syncs/latency 2).
`timescale 1ns/1ps
module tb_video_out_tgen;

  logic        clk = 1'b0;
  logic        rst, enable, fifo_ready, fifo_empty, clr_status;
  logic [1:0]  mode;
  logic [23:0] rd_data;
`ifdef VIDEO_OUT_TPG_EN
  logic        tpg_sel;
`endif

  logic        rd_en_a, vs_a, hs_a, de_a, fs_a, ufl_a;
  logic [7:0]  r_a, g_a, b_a;
  logic        rd_en_b, vs_b, hs_b, de_b, fs_b, ufl_b;
  logic [7:0]  r_b, g_b, b_b;
  logic [23:0] rgb_a, rgb_b;

  int checks   = 0;
  int failures = 0;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  always #5 clk = ~clk;

  video_out_tgen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(24), .FIFO_LAT(1)
  ) dut_a (
`ifdef VIDEO_OUT_TPG_EN
    .tpg_sel(tpg_sel),
`endif
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .fifo_ready(fifo_ready),
    .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data),
    .clr_status(clr_status), .vs(vs_a), .hs(hs_a), .de(de_a),
    .rgb_r(r_a), .rgb_g(g_a), .rgb_b(b_a), .frame_start(fs_a), .underflow(ufl_a)
  );

  video_out_tgen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(24), .FIFO_LAT(2)
  ) dut_b (
`ifdef VIDEO_OUT_TPG_EN
    .tpg_sel(tpg_sel),
`endif
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .fifo_ready(fifo_ready),
    .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data),
    .clr_status(clr_status), .vs(vs_b), .hs(hs_b), .de(de_b),
    .rgb_r(r_b), .rgb_g(g_b), .rgb_b(b_b), .frame_start(fs_b), .underflow(ufl_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; mode = 2'd0; fifo_ready = 1'b0;
    fifo_empty = 1'b0; clr_status = 1'b0; rd_data = '0;
`ifdef VIDEO_OUT_TPG_EN
    tpg_sel = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      tick();
      if (fs_a === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_frame_start got=timeout exp=frame_start within 200 clocks");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; fifo_ready = 1'b1; mode = 2'd1;
    fifo_empty = 1'b0; clr_status = 1'b0; rd_data = 24'h00F800;
    tick();
    tick();
    checks++;
    if ({de_a, fs_a, ufl_a, rd_en_a, rgb_a} !== 28'h0) begin
      failures++;
      $display("FAIL reset_a_outputs got=%h exp=0", {de_a, fs_a, ufl_a, rd_en_a, rgb_a});
    end
    checks++;
    if ({hs_a, vs_a} !== 2'b00) begin
      failures++;
      $display("FAIL reset_a_syncs got=%b exp=00", {hs_a, vs_a});
    end
    checks++;
    if ({hs_b, vs_b, de_b, rd_en_b, rgb_b} !== {2'b11, 26'h0}) begin
      failures++;
      $display("FAIL reset_b_outputs got=%h exp=%h", {hs_b, vs_b, de_b, rd_en_b, rgb_b}, {2'b11, 26'h0});
    end
    rst = 1'b0;
  endtask

  task automatic test_format();
    bit ok;
    int fs_cnt, p, ln, col;
    logic e_de, e_hs, e_vs, e_fs;
    logic [27:0] got, exp;
    do_reset();
    mode = 2'd1; rd_data = 24'h00F800; enable = 1'b1; fifo_ready = 1'b1;
    wait_fs(ok);
    fs_cnt = 0;
    for (int i = 0; i < 196; i++) begin
      p = i % 98; ln = p / 14; col = p % 14;
      e_de = (ln < 4) && (col < 8);
      e_hs = (col >= 10) && (col < 12);
      e_vs = (ln == 5);
      e_fs = (p == 0);
      exp  = {e_de, e_hs, e_vs, e_fs, e_de ? 24'hFF0000 : 24'h0};
      got  = {de_a, hs_a, vs_a, fs_a, rgb_a};
      if (fs_a === 1'b1) fs_cnt++;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL format_a idx=%0d got=%h exp=%h", i, got, exp);
      end
      if (i >= 1) begin
        p = (i - 1) % 98; ln = p / 14; col = p % 14;
        e_de = (ln < 4) && (col < 8);
        e_hs = (col >= 10) && (col < 12);
        e_vs = (ln == 5);
        e_fs = (p == 0);
        exp  = {e_de, !e_hs, !e_vs, e_fs, e_de ? 24'hFF0000 : 24'h0};
        got  = {de_b, hs_b, vs_b, fs_b, rgb_b};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL format_b idx=%0d got=%h exp=%h", i, got, exp);
        end
      end
      tick();
    end
    checks++;
    if (fs_cnt != 2) begin
      failures++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
    end
    checks++;
    if (ufl_a !== 1'b0) begin
      failures++;
      $display("FAIL format_no_underflow got=%b exp=0", ufl_a);
    end
  endtask

  task automatic test_start_gating();
    bit seen;
    do_reset();
    mode = 2'd0; rd_data = 24'h0000A5; enable = 1'b1; fifo_ready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (rd_en_a !== 1'b0 || rd_en_b !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL gating_no_read got=%b exp=0", seen);
    end
    fifo_ready = 1'b1;
    tick();
    checks++;
    if ({rd_en_a, de_a} !== 2'b10) begin
      failures++;
      $display("FAIL gating_first_read got=%b exp=10", {rd_en_a, de_a});
    end
    tick();
    checks++;
    if (de_a !== 1'b0) begin
      failures++;
      $display("FAIL gating_de_early got=%b exp=0", de_a);
    end
    tick();
    checks++;
    if ({de_a, fs_a, rgb_a, de_b} !== {2'b11, 24'hA5A5A5, 1'b0}) begin
      failures++;
      $display("FAIL gating_first_de_a got=%h exp=%h", {de_a, fs_a, rgb_a, de_b}, {2'b11, 24'hA5A5A5, 1'b0});
    end
    tick();
    checks++;
    if ({de_b, rgb_b} !== {1'b1, 24'hA5A5A5}) begin
      failures++;
      $display("FAIL gating_first_de_b got=%h exp=%h", {de_b, rgb_b}, {1'b1, 24'hA5A5A5});
    end
  endtask

  task automatic test_underflow();
    do_reset();
    mode = 2'd1; rd_data = 24'h00F800; enable = 1'b1; fifo_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    fifo_empty = 1'b1;
    checks++;
    if (rd_en_a !== 1'b1) begin
      failures++;
      $display("FAIL ufl_third_read got=%b exp=1", rd_en_a);
    end
    tick();
    fifo_empty = 1'b0;
    checks++;
    if ({ufl_a, rgb_a} !== {1'b1, 24'hFF0000}) begin
      failures++;
      $display("FAIL ufl_set got=%h exp=%h", {ufl_a, rgb_a}, {1'b1, 24'hFF0000});
    end
    tick();
    checks++;
    if ({de_a, rgb_a, ufl_b} !== {1'b1, 24'h0, 1'b1}) begin
      failures++;
      $display("FAIL ufl_black_a got=%h exp=%h", {de_a, rgb_a, ufl_b}, {1'b1, 24'h0, 1'b1});
    end
    tick();
    checks++;
    if ({rgb_a, de_b, rgb_b} !== {24'hFF0000, 1'b1, 24'h0}) begin
      failures++;
      $display("FAIL ufl_black_b got=%h exp=%h", {rgb_a, de_b, rgb_b}, {24'hFF0000, 1'b1, 24'h0});
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (ufl_a !== 1'b0) begin
      failures++;
      $display("FAIL ufl_clear got=%b exp=0", ufl_a);
    end
    fifo_empty = 1'b1; clr_status = 1'b1;
    tick();
    fifo_empty = 1'b0; clr_status = 1'b0;
    checks++;
    if (ufl_a !== 1'b1) begin
      failures++;
      $display("FAIL ufl_set_wins got=%b exp=1", ufl_a);
    end
    tick();
    checks++;
    if ({de_a, rgb_a} !== {1'b1, 24'h0}) begin
      failures++;
      $display("FAIL ufl_black_second got=%h exp=%h", {de_a, rgb_a}, {1'b1, 24'h0});
    end
  endtask

  task automatic test_mode_latch();
    bit ok;
    do_reset();
    mode = 2'd0; rd_data = 24'h123456; enable = 1'b1; fifo_ready = 1'b1;
    wait_fs(ok);
    checks++;
    if (rgb_a !== 24'h565656) begin
      failures++;
      $display("FAIL mode_raw8_first got=%h exp=565656", rgb_a);
    end
    for (int n = 0; n < 10; n++) tick();
    mode = 2'd2;
    for (int n = 0; n < 20; n++) tick();
    checks++;
    if ({de_a, rgb_a} !== {1'b1, 24'h565656}) begin
      failures++;
      $display("FAIL mode_midframe_hold got=%h exp=%h", {de_a, rgb_a}, {1'b1, 24'h565656});
    end
    wait_fs(ok);
    checks++;
    if (rgb_a !== 24'h123456) begin
      failures++;
      $display("FAIL mode_rgb888_next_a got=%h exp=123456", rgb_a);
    end
    tick();
    checks++;
    if ({fs_b, rgb_b} !== {1'b1, 24'h123456}) begin
      failures++;
      $display("FAIL mode_rgb888_next_b got=%h exp=%h", {fs_b, rgb_b}, {1'b1, 24'h123456});
    end
  endtask

  task automatic test_stop();
    bit ok, bad;
    do_reset();
    mode = 2'd1; rd_data = 24'h00F800; enable = 1'b1; fifo_ready = 1'b1;
    wait_fs(ok);
    for (int n = 0; n < 20; n++) tick();
    enable = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    checks++;
    if ({de_a, rgb_a} !== {1'b1, 24'hFF0000}) begin
      failures++;
      $display("FAIL stop_frame_continues got=%h exp=%h", {de_a, rgb_a}, {1'b1, 24'hFF0000});
    end
    bad = 1'b0;
    for (int i = 31; i <= 130; i++) begin
      tick();
      if (i == 75) begin
        checks++;
        if (vs_a !== 1'b1) begin
          failures++;
          $display("FAIL stop_vsync_reached got=%b exp=1", vs_a);
        end
      end
      if (i >= 98 && ({de_a, hs_a, vs_a, fs_a, rd_en_a, de_b, hs_b, vs_b, rd_en_b} !== 9'b000000110))
        bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle_after_frame got=%b exp=0", bad);
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    do_reset();
    mode = 2'd1; rd_data = 24'h00F800; enable = 1'b1; fifo_ready = 1'b1;
    wait_fs(ok);
    for (int n = 0; n < 11; n++) tick();
    checks++;
    if ({hs_a, hs_b} !== 2'b10) begin
      failures++;
      $display("FAIL rst_pre_hsync got=%b exp=10", {hs_a, hs_b});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({hs_b, de_b, rgb_b, hs_a, rd_en_a} !== {2'b10, 24'h0, 2'b00}) begin
      failures++;
      $display("FAIL rst_hsync_inactive got=%h exp=%h", {hs_b, de_b, rgb_b, hs_a, rd_en_a}, {2'b10, 24'h0, 2'b00});
    end
    wait_fs(ok);
    for (int n = 0; n < 3; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({de_a, rgb_a, de_b, rgb_b, fs_a, rd_en_a} !== 52'h0) begin
      failures++;
      $display("FAIL rst_active_pixel got=%h exp=0", {de_a, rgb_a, de_b, rgb_b, fs_a, rd_en_a});
    end
  endtask

`ifdef VIDEO_OUT_TPG_EN
  task automatic test_pattern();
    bit ok, seen;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    do_reset();
    tpg_sel = 1'b1; fifo_empty = 1'b1; mode = 2'd1;
    enable = 1'b1; fifo_ready = 1'b1;
    wait_fs(ok);
    seen = 1'b0;
    for (int i = 0; i < 98; i++) begin
      if (rd_en_a !== 1'b0 || rd_en_b !== 1'b0) seen = 1'b1;
      if (i < 8) begin
        checks++;
        if ({de_a, rgb_a} !== {1'b1, bars[i]}) begin
          failures++;
          $display("FAIL tpg_bar_a idx=%0d got=%h exp=%h", i, {de_a, rgb_a}, {1'b1, bars[i]});
        end
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if ({de_b, rgb_b} !== {1'b1, bars[i-1]}) begin
          failures++;
          $display("FAIL tpg_bar_b idx=%0d got=%h exp=%h", i - 1, {de_b, rgb_b}, {1'b1, bars[i-1]});
        end
      end
      tick();
    end
    checks++;
    if ({seen, ufl_a, ufl_b} !== 3'b000) begin
      failures++;
      $display("FAIL tpg_no_read got=%b exp=000", {seen, ufl_a, ufl_b});
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_format();
    test_start_gating();
    test_underflow();
    test_mode_latch();
    test_stop();
    test_reset_midline();
`ifdef VIDEO_OUT_TPG_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_out_tgen.md
Name: video_out_tgen

Overview:
Parametrised video output engine: programmable-timing raster generator, pixel-FIFO read control, and pixel unpacking to 8:8:8 RGB with aligned hs/vs/de. It sits between the frame-buffer read FIFO and the HDMI/DVI encoder. It supersedes the fixed-timing IP timing core plus fixed RAW8 path with:
- runtime pixel-format select;
- FIFO-fill-gated frame start;
- underflow detection.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, hsync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width
V_BP, 20, vertical back porch
HS_POL, 1, 1 = hs active-high, 0 = active-low
VS_POL, 1, same for vs
DATA_W, 16, FIFO data width (8..32)
FIFO_LAT, 1, FIFO read-to-data latency in clocks (1 or 2)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
enable  in  1  run request; sampled only at frame boundaries
mode  in  2  0 RAW8 grey, 1 RGB565, 2 RGB888, 3 reserved (black); sampled at frame start
fifo_ready  in  1  FIFO holds at least one line; gates frame start
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read strobe
fifo_rd_data  in  DATA_W  FIFO read data
clr_status  in  1  clears underflow flag
vs  out  1  vertical sync, polarity per VS_POL
hs  out  1  horizontal sync, polarity per HS_POL
de  out  1  active video
rgb_r  out  8  red
rgb_g  out  8  green
rgb_b  out  8  blue
frame_start  out  1  one-clock pulse with first de of a frame
underflow  out  1  sticky underflow flag

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of the four H params).
  - v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - Line order: active, FP, sync, BP. Frame order is the same.
- Internal timing signals:
  - hs_i = 1 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_i is the same rule applied to v_cnt.
  - de_i = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- FSM:
  - IDLE: counters held at 0, de_i = 0, syncs inactive, fifo_rd_en = 0. Go to WAIT when enable = 1.
  - WAIT: go to RUN when fifo_ready = 1. mode and enable are latched on this transition. Go back to IDLE if enable = 0.
  - RUN: counters free-run.
    - At the last pixel of a frame (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1): if enable = 0, go to IDLE.
    - Otherwise relatch mode and stay in RUN. No re-wait on fifo_ready after the first frame.
- Read strobe: fifo_rd_en = de_i while in RUN (combinational from the counter registers).
- Output pipeline:
  - hs/vs/de are delayed FIFO_LAT+1 clocks.
  - rgb is registered once after data return.
  - Net latency from fifo_rd_en to output pixel is FIFO_LAT+1 clocks; sync and data stay aligned.
- Unpacking:
  - RAW8: r = g = b = d[7:0].
  - RGB565: r = {d[15:11], d[15:13]}, g = {d[10:5], d[10:9]}, b = {d[4:0], d[4:2]}.
  - RGB888: r = d[23:16], g = d[15:8], b = d[7:0]; bits above DATA_W read as 0.
  - mode 3: 0/0/0.
  - rgb = 0 whenever the output de = 0.
- Underflow:
  - fifo_rd_en and fifo_empty in the same cycle sets underflow.
  - That pixel is output black; timing continues unchanged.
  - clr_status clears underflow; a simultaneous set wins.
- frame_start: pulses with the output de for h = 0, v = 0.
- Mid-frame changes to mode or enable have no effect until the frame boundary.
- Reset (any time, including mid-frame):
  - State returns to IDLE; counters 0; pipeline flushed.
  - de, fifo_rd_en, frame_start, underflow and rgb go to 0.
  - hs = ~HS_POL, vs = ~VS_POL (inactive level).

Optional Feature:
- Macro: VIDEO_OUT_TPG_EN.
- Defined: adds input tpg_sel (1 bit, latched at frame start). When latched = 1:
  - fifo_rd_en is forced 0 and underflow is not set.
  - rgb shows 8 vertical colour bars, bar index = h_cnt*8/H_ACTIVE. Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Latency and sync alignment are identical to the FIFO path.
- Undefined: no tpg_sel port; the FIFO path is always used.

Decomposition:
- Package video_out_pkg holds:
  - pix_mode_t enum (RAW8, RGB565, RGB888, RSVD);
  - H_TOTAL/V_TOTAL derivation functions;
  - colour-bar constant table.
- One sub-module, vo_pix_unpack: mode plus DATA_W data in, registered 24-bit RGB out.

Test Plan:
All scenarios use H 8/2/2/2 (H_TOTAL = 14) and V 4/1/1/1 (V_TOTAL = 7).
1. Format/timing: FIFO_LAT = 1, mode = RGB565, data 16'hF800, enable = 1, fifo_ready = 1 → per line:
   - 8 de clocks, rgb = FF/00/00;
   - hs high for 2 clocks, starting 2 clocks after de falls;
   - frame period 98 clocks;
   - frame_start once per frame.
2. Start gating: hold fifo_ready = 0 for 50 clocks after enable → fifo_rd_en stays 0. Raise fifo_ready → first fifo_rd_en next cycle; first de 2 clocks after it.
3. Underflow: fifo_empty = 1 on the 3rd read of line 0 → that pixel is 000000 and underflow = 1; clr_status clears it. Assert clr_status together with a new empty read → underflow stays 1.
4. Mode latching: switch mode from RAW8 to RGB888 mid-frame with data 0x123456 → current frame still grey (56/56/56); next frame outputs 12/34/56.
5. Stop and reset: drop enable mid-frame → frame completes, then IDLE with de = 0 and syncs inactive. Separately, assert rst mid-line with HS_POL = 0 → next cycle hs = 1, de = 0, rgb = 0.
6. Pattern (VIDEO_OUT_TPG_EN defined, tpg_sel = 1) → fifo_rd_en never asserts. Pixels 0..7 of an active line = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
